// File: rtl/regfile_ab.sv
// -----------------------------------------------------------------------------
// regfile_ab : multicycle-CPU general register file with registered A/B
//              operand latches.
//
// 32 x WIDTH registers, one write port, two read ports. Register 0 always
// reads as zero. Register SP_INDEX resets to SP_INIT; every other register
// resets to zero. The read ports feed the A/B latches. These latches load in
// the decode cycle and hold their values across the execute and memory cycles.
//
// Ports
//   Clk        in   1      system clock, rising-edge active
//   Reset      in   1      asynchronous, active-high reset
//   RegWrite   in   1      write enable for the write port
//   WriteReg   in   5      destination register index (rt/rd select result)
//   WriteData  in   WIDTH  data to write
//   ReadReg1   in   5      source index for operand A (rs)
//   ReadReg2   in   5      source index for operand B (rt)
//   LoadAB     in   1      capture enable for the A/B latches
//   A          out  WIDTH  registered operand A
//   B          out  WIDTH  registered operand B
//   Zero1      out  1      registered flag: ReadReg1 was 0 at the last A load
// -----------------------------------------------------------------------------
module regfile_ab #(
  parameter int               WIDTH    = 32,
  parameter int               SP_INDEX = 29,
  parameter logic [WIDTH-1:0] SP_INIT  = 32'h0000_03FC
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  input  logic             LoadAB,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Zero1
);

  // Register array. Entry 0 is never enabled for writing, so it stays at its
  // reset value of zero and synthesis reduces it to a constant.
  logic [WIDTH-1:0] regs_q [32];

  // One-hot write enables decoded from WriteReg.
  logic [31:0]      wr_en_s;

  // Operand values seen by the latches, including the same-edge write bypass.
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  // Operand latch state.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             zero1_q, zero1_d;

  // Returns the value a read port sees. When a register is written on the same
  // edge that the latches load, the latch receives the new data (write-first).
  function automatic logic [WIDTH-1:0] port_value(
    input logic [4:0]       idx,
    input logic             we,
    input logic [4:0]       widx,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] stored
  );
    logic [WIDTH-1:0] v;
    if (idx == 5'd0) begin
      v = '0;
    end else if (we && (widx == idx)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  // Decodes the 5-bit destination into one-hot enables. Bit 0 stays low, so
  // a write to r0 changes nothing.
  always_comb begin
    wr_en_s = 32'd0;
    for (int i = 1; i < 32; i++) begin
      if (RegWrite && (WriteReg == 5'(i))) begin
        wr_en_s[i] = 1'b1;
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  // Register array storage. Reset clears every entry except the stack pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_INIT : {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_en_s[i]) begin
          regs_q[i] <= WriteData;
        end
      end
    end
  end

  // Read-port muxes with the write-first bypass.
  always_comb begin
    rd1_s = port_value(ReadReg1, RegWrite, WriteReg, WriteData, regs_q[ReadReg1]);
    rd2_s = port_value(ReadReg2, RegWrite, WriteReg, WriteData, regs_q[ReadReg2]);
  end

  // Next-state logic for the operand latches. The latches hold unless LoadAB
  // is high.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    zero1_d = zero1_q;
    if (LoadAB) begin
      a_d     = rd1_s;
      b_d     = rd2_s;
      zero1_d = (ReadReg1 == 5'd0);
    end else begin
      a_d     = a_q;
      b_d     = b_q;
      zero1_d = zero1_q;
    end
  end

  // Operand latch registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q     <= '0;
      b_q     <= '0;
      zero1_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      zero1_q <= zero1_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign Zero1 = zero1_q;

endmodule

// File: tb/tb_regfile_ab.sv
// -----------------------------------------------------------------------------
// tb_regfile_ab : self-checking bench for regfile_ab.
// A behavioural model (an array of 32 words plus the expected A/B/Zero1)
// is updated on each rising edge and compared with the DUT outputs 1 time
// unit after that edge. The bench runs directed scenarios first and then
// randomized traffic.
// -----------------------------------------------------------------------------
module tb_regfile_ab;

  logic        Clk;
  logic        Reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        LoadAB;
  logic [31:0] A;
  logic [31:0] B;
  logic        Zero1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] mem [32];
  logic [31:0] ea, eb;
  logic        ez;

  regfile_ab #(.WIDTH(32), .SP_INDEX(29), .SP_INIT(32'h0000_03FC)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .LoadAB    (LoadAB),
    .A         (A),
    .B         (B),
    .Zero1     (Zero1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Watchdog that ends a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[29] = 32'h0000_03FC;
    ea = 32'h0;
    eb = 32'h0;
    ez = 1'b0;
  endtask

  // Returns the value register i contributes to a latch on an edge, given
  // the write on that same edge.
  function automatic logic [31:0] mval(input logic [4:0] i, input logic we,
                                       input logic [4:0] wr, input logic [31:0] wd);
    if (i == 5'd0) return 32'h0;
    if (we && wr == i) return wd;
    return mem[i];
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".A"}, A, ea);
    check({tag, ".B"}, B, eb);
    check({tag, ".Zero1"}, {31'h0, Zero1}, {31'h0, ez});
  endtask

  // Applies one clock cycle of inputs, advances the model and checks the DUT.
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input logic ld,
                      input string tag);
    RegWrite  = we;
    WriteReg  = wr;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
    LoadAB    = ld;
    @(posedge Clk);
    if (ld) begin
      ea = mval(r1, we, wr, wd);
      eb = mval(r2, we, wr, wd);
      ez = (r1 == 5'd0);
    end
    if (we && wr != 5'd0) mem[wr] = wd;
    #1;
    check_outs(tag);
  endtask

  // Raises Reset in the middle of a cycle while a write is pending. The
  // outputs must clear at once and stay cleared across an edge.
  task automatic async_reset(input string tag);
    RegWrite  = 1'b1;
    WriteReg  = 5'd17;
    WriteData = 32'hCAFE_F00D;
    LoadAB    = 1'b1;
    ReadReg1  = 5'd17;
    ReadReg2  = 5'd29;
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_outs({tag, ".imm"});
    @(posedge Clk);
    #1;
    check_outs({tag, ".held"});
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    logic [31:0] k;
    logic [4:0]  r1, r2, wr;
    logic        we, ld;
    logic [31:0] wd;

    Reset = 1'b1; RegWrite = 1'b0; WriteReg = 5'd0; WriteData = 32'h0;
    ReadReg1 = 5'd0; ReadReg2 = 5'd0; LoadAB = 1'b0;
    model_reset();
    #1;
    check_outs("por");
    @(posedge Clk);
    #3;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_outs("por_rel");

    // Put non-zero values in the latches, then reset mid-cycle.
    step(1'b0, 5'd0, 32'h0, 5'd29, 5'd29, 1'b1, "pre_rst");
    check("pre_rst.sp", A, 32'h0000_03FC);
    async_reset("rst1");
    step(1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b1, "rst_sp");
    check("rst_sp.A", A, 32'h0000_03FC);
    check("rst_sp.B", B, 32'h0);

    // Basic write and read-back.
    step(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, "wr8");
    step(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b1, "rd8");
    check("rd8.A", A, 32'hDEAD_BEEF);
    check("rd8.B", B, 32'hDEAD_BEEF);
    check("rd8.Z", {31'h0, Zero1}, 32'h0);

    // Writes to r0 are discarded.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd8, 5'd8, 1'b0, "wr0");
    step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, "rd0");
    check("rd0.A", A, 32'h0);
    check("rd0.Z", {31'h0, Zero1}, 32'h1);

    // Same-edge write is visible to the latch.
    step(1'b1, 5'd3, 32'h1, 5'd0, 5'd0, 1'b0, "wr3");
    step(1'b1, 5'd3, 32'h1234_5678, 5'd8, 5'd3, 1'b1, "byp");
    check("byp.B", B, 32'h1234_5678);
    check("byp.A", A, 32'hDEAD_BEEF);

    // Latches hold while LoadAB is low.
    step(1'b1, 5'd4, 32'hA5, 5'd0, 5'd0, 1'b0, "wr4");
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, "ld4");
    step(1'b1, 5'd4, 32'h5A, 5'd4, 5'd4, 1'b0, "hold0");
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, "hold");
      check("hold.A", A, 32'hA5);
    end
    step(1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b1, "reld4");
    check("reld4.A", A, 32'h5A);

    // Write every register, then read back all (i, 31-i) pairs.
    for (int i = 1; i < 32; i++) begin
      k = 32'h0101_0101 * 32'(i);
      step(1'b1, 5'(i), k, 5'(31 - i), 5'(i), 1'b0, "dec_wr");
    end
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, "dec_rd");
      k = 32'h0101_0101 * 32'(i);
      check("dec.A", A, k);
      k = 32'h0101_0101 * 32'(31 - i);
      check("dec.B", B, k);
    end

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wr = 5'($urandom);
      wd = $urandom;
      r1 = 5'($urandom);
      r2 = (n % 7 == 0) ? r1 : 5'($urandom);
      if (n % 5 == 0) r1 = wr;
      ld = ($urandom_range(0, 3) != 0);
      step(we, wr, wd, r1, r2, ld, "rand");
    end

    // Reset while reg[17] is being written, then confirm the array is cleared.
    async_reset("rst17");
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1, "post_rst");
      k = (i == 29) ? 32'h0000_03FC : 32'h0;
      check("post_rst.A", A, k);
      k = ((31 - i) == 29) ? 32'h0000_03FC : 32'h0;
      check("post_rst.B", B, k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_ab.md
Name: regfile_ab

Overview:
- Multicycle-CPU register file: 32 x WIDTH general registers.
- Single write port addressed by the 5-bit destination-register select produced by the datapath's rt/rd 2:1 mux; this block is the consumer that decodes that address.
- Two read ports feed registered A/B operand latches, loaded in the decode cycle and held across execute/memory cycles.
- Sits between instruction-register field decode and the ALU-input muxes.

Parameters:
WIDTH, 32, data width of each register and of A/B
SP_INDEX, 29, register index given a non-zero reset value
SP_INIT, 32'h0000_03FC, reset value of register SP_INDEX

Ports:
Clk  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-high reset
RegWrite  input  1  write enable for the write port
WriteReg  input  5  destination register index (from rt/rd select mux)
WriteData  input  WIDTH  data to write
ReadReg1  input  5  source index for operand A (rs)
ReadReg2  input  5  source index for operand B (rt)
LoadAB  input  1  capture enable for A/B latches
A  output  WIDTH  registered operand A
B  output  WIDTH  registered operand B
Zero1  output  1  registered flag, ReadReg1 was 0 when A last loaded

Behaviour:
- One clock (Clk); Reset asynchronous, active-high; all state updates on rising Clk edge when Reset low.
- Reset asserted (any time, including mid-write): immediately all registers = 0 except reg[SP_INDEX] = SP_INIT; A = 0, B = 0, Zero1 = 0. Held while Reset high; RegWrite ignored.
- Write: at rising edge with RegWrite=1 and WriteReg!=0, reg[WriteReg] <= WriteData.
  - WriteReg=0 with RegWrite=1: no state change; reg[0] always reads 0.
  - Exactly one register is updated per write (5-to-32 one-hot decode). No other register changes.
- Read/latch: at rising edge with LoadAB=1:
  - A <= value(ReadReg1); B <= value(ReadReg2); Zero1 <= (ReadReg1==0).
  - value(i) = 0 if i==0.
  - value(i) = WriteData if RegWrite=1 and WriteReg==i, i!=0 (write-first bypass: same-edge write is visible in the latch).
  - Otherwise value(i) = reg[i].
- LoadAB=0: A, B, Zero1 hold their previous values regardless of writes to the registers they were loaded from.
- Latency: write data visible in A/B one edge after the write edge via the array, or on the same edge via bypass. A/B change only at edges, never combinationally.
- ReadReg1==ReadReg2: A and B receive identical values.
- Simultaneous LoadAB and RegWrite to an unrelated register: both take effect; the latch takes the pre-write array value.
- No X propagation: every register has a defined reset value. No internal state machine beyond the array and latches; the controlling FSM lives in the control unit.

Test Plan:
- Reset sequence: pulse Reset mid-cycle (asynchronous, not edge-aligned) -> A=0, B=0, Zero1=0 immediately. Then LoadAB=1, ReadReg1=29, ReadReg2=5 -> A=32'h3FC, B=0.
- Basic write/read: write reg[8]=32'hDEADBEEF. Next edge LoadAB=1, ReadReg1=8, ReadReg2=8 -> A=B=32'hDEADBEEF, Zero1=0.
- r0 protection: RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF. Then load ReadReg1=0 -> A=0, Zero1=1.
- Bypass: same edge RegWrite=1, WriteReg=3, WriteData=32'h12345678, LoadAB=1, ReadReg2=3 (reg[3] previously 32'h1) -> B=32'h12345678.
- Hold: load A from reg[4]=32'hA5, then LoadAB=0 and write reg[4]=32'h5A -> A stays 32'hA5 for 3 cycles. Next LoadAB=1 -> A=32'h5A.
- Decode exhaustive: write reg[i]=i*32'h01010101 for i=1..31, then read all pairs (i, 31-i) -> each latch matches the expected value, reg[0]=0, no aliasing. Assert Reset during write of reg[17] -> all regs cleared, reg[29]=32'h3FC.
